// File: rtl/keyboard_tracker.sv
// PS/2 set-2 keyboard receiver tracking ten game keys as held levels or press pulses.
// Define KBD_PARITY_CHECK_EN to drop frames with bad odd parity (otherwise parity is ignored).
module keyboard_tracker #(
    parameter int PULSE_OR_HOLD  = 0,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic clock,
    input  logic reset,
    inout  wire  PS2_CLK,
    inout  wire  PS2_DAT,
    output logic w,
    output logic a,
    output logic s,
    output logic d,
    output logic left,
    output logic right,
    output logic up,
    output logic down,
    output logic space,
    output logic enter
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int NK = 10;

    logic          ps2c_s1_q, ps2c_s2_q, ps2c_prev_q;
    logic          ps2d_s1_q, ps2d_s2_q;
    logic          fall;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          byte_vld_q, byte_vld_d;
    logic [7:0]    byte_q, byte_d;
    logic          ext_q, ext_d, brk_q, brk_d;
    logic          key_cmd;
    logic          frame_ok;
    logic [NK-1:0] hit, held_q, held_d, key_q, key_d;

`ifdef KBD_PARITY_CHECK_EN
    logic parity_q, parity_d;
    assign frame_ok = ^{parity_q, shift_q};
`else
    assign frame_ok = 1'b1;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ps2c_s1_q   <= 1'b1;
            ps2c_s2_q   <= 1'b1;
            ps2c_prev_q <= 1'b1;
            ps2d_s1_q   <= 1'b1;
            ps2d_s2_q   <= 1'b1;
        end else begin
            ps2c_s1_q   <= PS2_CLK;
            ps2c_s2_q   <= ps2c_s1_q;
            ps2c_prev_q <= ps2c_s2_q;
            ps2d_s1_q   <= PS2_DAT;
            ps2d_s2_q   <= ps2d_s1_q;
        end
    end

    assign fall = ps2c_prev_q & ~ps2c_s2_q;

    always_comb begin
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        to_cnt_d   = to_cnt_q;
        byte_vld_d = 1'b0;
        byte_d     = byte_q;
`ifdef KBD_PARITY_CHECK_EN
        parity_d   = parity_q;
`endif
        if (fall) begin
            to_cnt_d = '0;
            if (bit_cnt_q == 4'd0) begin
                if (!ps2d_s2_q)
                    bit_cnt_d = 4'd1;
            end else if (bit_cnt_q <= 4'd8) begin
                shift_d   = {ps2d_s2_q, shift_q[7:1]};
                bit_cnt_d = bit_cnt_q + 4'd1;
            end else if (bit_cnt_q == 4'd9) begin
`ifdef KBD_PARITY_CHECK_EN
                parity_d  = ps2d_s2_q;
`endif
                bit_cnt_d = 4'd10;
            end else begin
                bit_cnt_d = 4'd0;
                if (ps2d_s2_q && frame_ok) begin
                    byte_vld_d = 1'b1;
                    byte_d     = shift_q;
                end
            end
        end else if (bit_cnt_q != 4'd0) begin
            // A stalled frame is abandoned so the next start bit resynchronises.
            if (to_cnt_q == TW'(TIMEOUT_CYCLES)) begin
                bit_cnt_d = 4'd0;
                to_cnt_d  = '0;
            end else begin
                to_cnt_d = to_cnt_q + 1'b1;
            end
        end
    end

    // Bit order: w a s d left right up down space enter.
    always_comb begin
        hit = '0;
        if (ext_q) begin
            case (byte_q)
                8'h6B:   hit[4] = 1'b1;
                8'h74:   hit[5] = 1'b1;
                8'h75:   hit[6] = 1'b1;
                8'h72:   hit[7] = 1'b1;
                default: hit = '0;
            endcase
        end else begin
            case (byte_q)
                8'h1D:   hit[0] = 1'b1;
                8'h1C:   hit[1] = 1'b1;
                8'h1B:   hit[2] = 1'b1;
                8'h23:   hit[3] = 1'b1;
                8'h29:   hit[8] = 1'b1;
                8'h5A:   hit[9] = 1'b1;
                default: hit = '0;
            endcase
        end
    end

    assign key_cmd = byte_vld_q && (byte_q != 8'hE0) && (byte_q != 8'hF0);

    always_comb begin
        ext_d = ext_q;
        brk_d = brk_q;
        if (byte_vld_q) begin
            if (byte_q == 8'hE0) begin
                ext_d = 1'b1;
            end else if (byte_q == 8'hF0) begin
                brk_d = 1'b1;
            end else begin
                ext_d = 1'b0;
                brk_d = 1'b0;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NK; gi++) begin : g_key
            assign held_d[gi] = (key_cmd && hit[gi]) ? ~brk_q : held_q[gi];
            if (PULSE_OR_HOLD != 0) begin : g_pulse
                assign key_d[gi] = key_cmd & hit[gi] & ~brk_q & ~held_q[gi];
            end else begin : g_hold
                assign key_d[gi] = held_d[gi];
            end
        end
    endgenerate

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bit_cnt_q  <= 4'd0;
            shift_q    <= 8'd0;
            to_cnt_q   <= '0;
            byte_vld_q <= 1'b0;
            byte_q     <= 8'd0;
            ext_q      <= 1'b0;
            brk_q      <= 1'b0;
            held_q     <= '0;
            key_q      <= '0;
`ifdef KBD_PARITY_CHECK_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            to_cnt_q   <= to_cnt_d;
            byte_vld_q <= byte_vld_d;
            byte_q     <= byte_d;
            ext_q      <= ext_d;
            brk_q      <= brk_d;
            held_q     <= held_d;
            key_q      <= key_d;
`ifdef KBD_PARITY_CHECK_EN
            parity_q   <= parity_d;
`endif
        end
    end

    assign {enter, space, down, up, right, left, d, s, a, w} = key_q;

endmodule

// File: tb/tb_keyboard_tracker.sv
// Directed bench for keyboard_tracker: one hold-mode and one pulse-mode instance share the PS/2 lines.
`timescale 1ns/1ps
module tb_keyboard_tracker;
    localparam int TO = 2000;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic reset;
    logic ps2c_drv, ps2d_drv;
    wire  ps2_clk_w = ps2c_drv;
    wire  ps2_dat_w = ps2d_drv;

    logic h_w, h_a, h_s, h_d, h_left, h_right, h_up, h_down, h_space, h_enter;
    logic p_w, p_a, p_s, p_d, p_left, p_right, p_up, p_down, p_space, p_enter;
    logic [9:0] hv, pv;
    assign hv = {h_enter, h_space, h_down, h_up, h_right, h_left, h_d, h_s, h_a, h_w};
    assign pv = {p_enter, p_space, p_down, p_up, p_right, p_left, p_d, p_s, p_a, p_w};

    keyboard_tracker #(.PULSE_OR_HOLD(0), .TIMEOUT_CYCLES(TO)) dut_hold (
        .clock(clock), .reset(reset), .PS2_CLK(ps2_clk_w), .PS2_DAT(ps2_dat_w),
        .w(h_w), .a(h_a), .s(h_s), .d(h_d), .left(h_left), .right(h_right),
        .up(h_up), .down(h_down), .space(h_space), .enter(h_enter));

    keyboard_tracker #(.PULSE_OR_HOLD(1), .TIMEOUT_CYCLES(TO)) dut_pulse (
        .clock(clock), .reset(reset), .PS2_CLK(ps2_clk_w), .PS2_DAT(ps2_dat_w),
        .w(p_w), .a(p_a), .s(p_s), .d(p_d), .left(p_left), .right(p_right),
        .up(p_up), .down(p_down), .space(p_space), .enter(p_enter));

    int n_checks = 0;
    int n_fail   = 0;

    // Pulse-mode enter activity: total high cycles and number of rising edges.
    int   enter_hi   = 0;
    int   enter_rise = 0;
    logic enter_prev = 1'b0;
    always @(negedge clock) begin
        if (p_enter) enter_hi <= enter_hi + 1;
        if (p_enter && !enter_prev) enter_rise <= enter_rise + 1;
        enter_prev <= p_enter;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clock);
    endtask

    function automatic logic [10:0] mk(input logic [7:0] b, input logic par_ok);
        logic par;
        par = par_ok ? ~^b : ^b;
        return {1'b1, par, b, 1'b0};
    endfunction

    task automatic ps2_bit(input logic b);
        ps2d_drv = b;
        wait_clk(10);
        ps2c_drv = 1'b0;
        wait_clk(20);
        ps2c_drv = 1'b1;
        wait_clk(10);
    endtask

    task automatic send_bits(input logic [10:0] f, input int n);
        for (int i = 0; i < n; i++) ps2_bit(f[i]);
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_bits(mk(b, 1'b1), 11);
        wait_clk(20);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        ps2c_drv = 1'b1;
        ps2d_drv = 1'b1;
        wait_clk(3);
        reset = 1'b1;
        wait_clk(3);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        ps2c_drv = 1'b1;
        ps2d_drv = 1'b1;
        wait_clk(3);
        n_checks++;
        if (hv !== 10'h000) begin n_fail++; $display("FAIL reset_hold: got %b expected %b", hv, 10'h000); end
        n_checks++;
        if (pv !== 10'h000) begin n_fail++; $display("FAIL reset_pulse: got %b expected %b", pv, 10'h000); end
        reset = 1'b1;
        wait_clk(3);
    endtask

    task automatic test_hold_w();
        logic [10:0] f;
        do_reset();
        f = mk(8'h1D, 1'b1);
        send_bits(f, 10);
        ps2d_drv = 1'b1;
        wait_clk(10);
        ps2c_drv = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        n_checks++;
        if (hv !== 10'h001) begin n_fail++; $display("FAIL w_latency: got %b expected %b", hv, 10'h001); end
        wait_clk(20);
        ps2c_drv = 1'b1;
        wait_clk(30);
        n_checks++;
        if (hv !== 10'h001) begin n_fail++; $display("FAIL w_held: got %b expected %b", hv, 10'h001); end
        send_byte(8'hF0);
        send_byte(8'h1D);
        n_checks++;
        if (hv !== 10'h000) begin n_fail++; $display("FAIL w_release: got %b expected %b", hv, 10'h000); end
    endtask

    task automatic test_extended();
        do_reset();
        send_byte(8'hE0);
        send_byte(8'h75);
        n_checks++;
        if (hv !== 10'h040) begin n_fail++; $display("FAIL up_press: got %b expected %b", hv, 10'h040); end
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h75);
        n_checks++;
        if (hv !== 10'h000) begin n_fail++; $display("FAIL up_release: got %b expected %b", hv, 10'h000); end
        send_byte(8'h75);
        n_checks++;
        if (hv !== 10'h000) begin n_fail++; $display("FAIL keypad8_ignored: got %b expected %b", hv, 10'h000); end
        send_byte(8'hE0);
        send_byte(8'h5A);
        n_checks++;
        if (hv !== 10'h000) begin n_fail++; $display("FAIL keypad_enter_ignored: got %b expected %b", hv, 10'h000); end
        // The E0 flag must have been consumed by 5A, so a plain 1D is still w.
        send_byte(8'h1D);
        n_checks++;
        if (hv !== 10'h001) begin n_fail++; $display("FAIL flag_cleared: got %b expected %b", hv, 10'h001); end
    endtask

    task automatic test_pulse();
        int r0, h0;
        do_reset();
        r0 = enter_rise;
        h0 = enter_hi;
        send_byte(8'h5A);
        n_checks++;
        if (enter_rise - r0 != 1 || enter_hi - h0 != 1) begin
            n_fail++; $display("FAIL pulse_first: got rises=%0d high=%0d expected 1/1", enter_rise - r0, enter_hi - h0);
        end
        send_byte(8'h5A);
        send_byte(8'h5A);
        n_checks++;
        if (enter_rise - r0 != 1 || enter_hi - h0 != 1) begin
            n_fail++; $display("FAIL pulse_typematic: got rises=%0d high=%0d expected 1/1", enter_rise - r0, enter_hi - h0);
        end
        send_byte(8'hF0);
        send_byte(8'h5A);
        n_checks++;
        if (enter_rise - r0 != 1 || enter_hi - h0 != 1) begin
            n_fail++; $display("FAIL pulse_break: got rises=%0d high=%0d expected 1/1", enter_rise - r0, enter_hi - h0);
        end
        send_byte(8'h5A);
        n_checks++;
        if (enter_rise - r0 != 2 || enter_hi - h0 != 2) begin
            n_fail++; $display("FAIL pulse_repress: got rises=%0d high=%0d expected 2/2", enter_rise - r0, enter_hi - h0);
        end
        n_checks++;
        if (hv !== 10'h200) begin n_fail++; $display("FAIL enter_hold: got %b expected %b", hv, 10'h200); end
    endtask

    task automatic test_two_keys();
        do_reset();
        send_byte(8'h1C);
        send_byte(8'h23);
        n_checks++;
        if (hv !== 10'h00A) begin n_fail++; $display("FAIL a_d_both: got %b expected %b", hv, 10'h00A); end
        send_byte(8'hF0);
        send_byte(8'h1C);
        n_checks++;
        if (hv !== 10'h008) begin n_fail++; $display("FAIL a_release: got %b expected %b", hv, 10'h008); end
    endtask

    task automatic test_parity();
        do_reset();
        send_bits(mk(8'h29, 1'b0), 11);
        wait_clk(20);
        n_checks++;
`ifdef KBD_PARITY_CHECK_EN
        if (hv !== 10'h000) begin n_fail++; $display("FAIL bad_parity_dropped: got %b expected %b", hv, 10'h000); end
`else
        if (hv !== 10'h100) begin n_fail++; $display("FAIL bad_parity_accepted: got %b expected %b", hv, 10'h100); end
`endif
        send_byte(8'h29);
        n_checks++;
        if (hv !== 10'h100) begin n_fail++; $display("FAIL space_valid: got %b expected %b", hv, 10'h100); end
    endtask

    task automatic test_timeout();
        do_reset();
        send_bits(mk(8'h1D, 1'b1), 5);
        wait_clk(TO + 100);
        send_byte(8'h1B);
        n_checks++;
        if (hv !== 10'h004) begin n_fail++; $display("FAIL timeout_resync: got %b expected %b", hv, 10'h004); end
    endtask

    task automatic test_reset_midframe();
        send_byte(8'h1C);
        n_checks++;
        if (hv !== 10'h006) begin n_fail++; $display("FAIL pre_reset_keys: got %b expected %b", hv, 10'h006); end
        send_bits(mk(8'h23, 1'b1), 5);
        reset = 1'b0;
        #1;
        n_checks++;
        if (hv !== 10'h000) begin n_fail++; $display("FAIL async_reset_hold: got %b expected %b", hv, 10'h000); end
        n_checks++;
        if (pv !== 10'h000) begin n_fail++; $display("FAIL async_reset_pulse: got %b expected %b", pv, 10'h000); end
        wait_clk(2);
        reset = 1'b1;
        wait_clk(5);
        send_byte(8'h1C);
        n_checks++;
        if (hv !== 10'h002) begin n_fail++; $display("FAIL after_reset_frame: got %b expected %b", hv, 10'h002); end
    endtask

    initial begin
        reset = 1'b0;
        ps2c_drv = 1'b1;
        ps2d_drv = 1'b1;
        test_reset();
        test_hold_w();
        test_extended();
        test_pulse();
        test_two_keys();
        test_parity();
        test_timeout();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/keyboard_tracker.md
Name: keyboard_tracker

Overview:
- PS/2 keyboard receiver and key-state tracker for game input.
- Receives set-2 scan codes over the PS/2 pins and decodes make/break sequences, including E0 extended and F0 break prefixes.
- Presents ten key signals (W, A, S, D, four arrows, space, enter) to game logic as held levels or single-cycle pulses.
- Sits between the board's PS/2 pins and the top-level controller, which does its own edge detection in hold mode.

Parameters:
- PULSE_OR_HOLD, 0. 0 = hold mode: output high while the key is down. 1 = pulse mode: one-cycle pulse per new press.
- TIMEOUT_CYCLES, 50000. Clock cycles with no PS2_CLK falling edge mid-frame before the partial frame is discarded (1 ms at 50 MHz).

Ports:
- clock  in  1  system clock, 50 MHz nominal.
- reset  in  1  asynchronous, active-low reset.
- PS2_CLK  inout  1  PS/2 clock. Never driven by this block (high-Z); read only.
- PS2_DAT  inout  1  PS/2 data. Never driven (high-Z); read only.
- w, a, s, d  out  1 each  letter key state or pulse.
- left, right, up, down  out  1 each  arrow key state or pulse.
- space, enter  out  1 each  key state or pulse.

Behaviour:
- Reset (reset=0, asynchronous): all ten outputs 0; bit counter 0; extended and break prefix flags cleared; synchronizers set to 1; timeout counter 0.
- Input conditioning: PS2_CLK and PS2_DAT each pass through a 2-flop synchronizer. A falling edge is detected when the previous synchronized clock is 1 and the current one is 0.
- Frame format: 11 bits sampled on successive falling edges.
  - bit0 start (must be 0); bits1-8 data, LSB first; bit9 odd parity; bit10 stop (must be 1).
  - A start bit of 1 is ignored and the counter stays at 0.
  - A bad stop bit discards the frame.
  - Parity checking follows the Optional Feature.
- Timeout: counter clears on every falling edge. If it reaches TIMEOUT_CYCLES while 0 < bit count < 11, the counter and partial frame are discarded.
- Byte handling, one clock after a valid frame completes:
  - E0: set the extended flag.
  - F0: set the break flag.
  - Any other byte: this is the key code. Apply it with the current flags, then clear both flags.
- Key map, non-extended codes: 1D=w, 1C=a, 1B=s, 23=d, 29=space, 5A=enter.
- Key map, extended (E0-prefixed) codes: 6B=left, 74=right, 75=up, 72=down.
- Non-extended 6B/74/75/72 (keypad) and E0 5A (keypad enter) map to nothing.
- Unmapped codes are consumed and only clear the flags.
- Internal held[] register per key: a make code sets it to 1, a break code (F0 prefix) clears it to 0.
- Hold mode: output = held[].
- Pulse mode: output is high for exactly one clock when a make code arrives while held[] is 0. Typematic repeat makes while held produce no pulse; a break produces no pulse.
- Latency: key output changes no more than 4 clock cycles after the stop-bit falling edge on the pin (2 synchronizer + edge detect + decode).
- Multiple keys are tracked independently; simultaneous holds are all reported.
- Reset mid-frame discards the partial frame and clears all state.

Optional Feature:
- Macro KBD_PARITY_CHECK_EN.
- Defined: a frame whose 9 bits (data + parity) do not have odd parity is discarded silently. Flags and key states are unchanged.
- Undefined: the parity bit is ignored, and any frame with correct start and stop bits is accepted.

Test Plan:
- Reset, then frame 0x1D (parity 1, stop 1), hold mode -> w=1 within 4 cycles of the stop edge; then F0,1D -> w=0; all other outputs stay 0 throughout.
- Hold mode, E0,75 -> up=1; E0,F0,75 -> up=0. Non-extended 75 -> up stays 0.
- PULSE_OR_HOLD=1, send 5A three times (typematic), then F0,5A, then 5A -> enter pulses exactly one cycle after the first and last make only.
- Hold mode, press 1C then 23, release 1C -> a=1,d=1, then a=0,d=1.
- 0x29 sent with parity 0 and KBD_PARITY_CHECK_EN defined -> space stays 0; next valid 0x29 -> space=1. Same bad frame without the macro -> space=1.
- Send 5 bits of a frame, idle 50000 cycles, then a full valid 0x1B -> s=1 (the partial frame is dropped). Assert reset mid-frame -> all outputs 0 immediately.
